// File: rtl/memory_arbiter_if.sv
// Requester and memory-side signals of memory_arbiter, bundled for the arbiter port.
// slave = arbiter side, master = requesters plus memory macro side.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            req;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic [1:0]            ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin two-port arbiter for the single-port memory: one transaction in flight.
// Optional ARB_STATS_EN adds grant_count0/1 and conflict_count wrap-around counters.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    memory_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
    ,
    output logic [10:0]       grant_count0,
    output logic [10:0]       grant_count1,
    output logic [10:0]       conflict_count
`endif
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("memory_arbiter: LATENCY must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic                  owner, owner_nx;
    logic                  last_grant, last_grant_nx;
    logic                  contested;
    logic [1:0]            ack_nx;
    logic [DATA_WIDTH-1:0] rdata_nx;
    logic                  busy_nx;
    logic                  en_nx;
    logic                  we_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        ack_nx        = 2'b00;
        rdata_nx      = bus.rdata;
        busy_nx       = bus.busy;
        en_nx         = bus.mem_en;
        we_nx         = bus.mem_we;
        addr_nx       = bus.mem_addr;
        wdata_nx      = bus.mem_wdata;
        contested     = (bus.req == 2'b11);

        unique case (state)
            IDLE: begin
                en_nx   = 1'b0;
                we_nx   = 1'b0;
                busy_nx = 1'b0;
                if (bus.req != 2'b00) begin
                    // On a tie the port that did not win last time goes first.
                    owner_nx      = contested ? ~last_grant : bus.req[1];
                    last_grant_nx = owner_nx;
                    en_nx         = 1'b1;
                    we_nx         = bus.we[owner_nx];
                    addr_nx       = owner_nx ? bus.addr1  : bus.addr0;
                    wdata_nx      = owner_nx ? bus.wdata1 : bus.wdata0;
                    busy_nx       = 1'b1;
                    cnt_nx        = 4'd0;
                    state_nx      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == LAST) begin
                    if (!bus.mem_we) rdata_nx = bus.mem_rdata;
                    ack_nx   = owner ? 2'b10 : 2'b01;
                    en_nx    = 1'b0;
                    we_nx    = 1'b0;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            bus.ack       <= 2'b00;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            owner         <= owner_nx;
            last_grant    <= last_grant_nx;
            bus.ack       <= ack_nx;
            bus.rdata     <= rdata_nx;
            bus.busy      <= busy_nx;
            bus.mem_en    <= en_nx;
            bus.mem_we    <= we_nx;
            bus.mem_addr  <= addr_nx;
            bus.mem_wdata <= wdata_nx;
        end
    end

`ifdef ARB_STATS_EN
    logic contested_grant;
    assign contested_grant = (state == IDLE) && contested;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_count0   <= 11'd0;
            grant_count1   <= 11'd0;
            conflict_count <= 11'd0;
        end else begin
            if (bus.ack[0])      grant_count0   <= grant_count0 + 11'd1;
            if (bus.ack[1])      grant_count1   <= grant_count1 + 11'd1;
            if (contested_grant) conflict_count <= conflict_count + 11'd1;
        end
    end
`endif

endmodule
